// File: rtl/uart_pkg.sv
// Frame-format types shared by the UART transmitter and receiver so that
// both ends of a link agree on parity and stop-bit encodings.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic {
        STOP_BITS_1 = 1'b0,
        STOP_BITS_2 = 1'b1
    } stop_bits_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: takes a byte over valid/ready and sends it on tx as
// start, 5-8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  num_data_bits,
    input  parity_t     parity,
    input  stop_bits_t  stop_bits,
    input  logic [15:0] clks_per_bit,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      r_state;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_cnt;
    logic [15:0] r_cpb;
    logic [2:0]  r_bitIdx;
    logic [2:0]  r_lastIdx;
    logic        r_stopIdx;
    logic [7:0]  r_data;
    parity_t     r_parity;
    stop_bits_t  r_stop;

    logic [3:0]  w_numBits;
    logic [7:0]  w_mask;
    logic [15:0] w_cpb;
    logic        w_bitEnd;

    always_comb begin
        w_numBits = num_data_bits;
        if (num_data_bits < 4'd5) begin
            w_numBits = 4'd5;
        end else if (num_data_bits > 4'd8) begin
            w_numBits = 4'd8;
        end
    end

    // Unsent upper bits are masked off at latch time so parity is a plain XOR.
    assign w_mask   = 8'hFF >> (4'd8 - w_numBits);
    assign w_cpb    = (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;
    assign w_bitEnd = (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= 16'd0;
            r_cpb     <= 16'd1;
            r_bitIdx  <= 3'd0;
            r_lastIdx <= 3'd7;
            r_stopIdx <= 1'b0;
            r_data    <= 8'd0;
            r_parity  <= PARITY_NONE;
            r_stop    <= STOP_BITS_1;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE) begin
                r_cnt <= w_bitEnd ? (r_cpb - 16'd1) : (r_cnt - 16'd1);
            end
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_data    <= tx_data & w_mask;
                        r_lastIdx <= 3'(w_numBits - 4'd1);
                        r_parity  <= parity;
                        r_stop    <= stop_bits;
                        r_cpb     <= w_cpb;
                        r_cnt     <= w_cpb - 16'd1;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bitEnd) begin
                        r_bitIdx <= 3'd0;
                        r_tx     <= r_data[0];
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        if (r_bitIdx != r_lastIdx) begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_tx     <= r_data[r_bitIdx + 3'd1];
                        end else if (r_parity != PARITY_NONE) begin
                            r_tx    <= (^r_data) ^ (r_parity == PARITY_ODD);
                            r_state <= PARITY;
                        end else begin
                            r_tx      <= 1'b1;
                            r_stopIdx <= 1'b0;
                            r_state   <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_bitEnd) begin
                        r_tx      <= 1'b1;
                        r_stopIdx <= 1'b0;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        if (r_stop == STOP_BITS_2 && !r_stopIdx) begin
                            r_stopIdx <= 1'b1;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame table, mid-frame reset,
// and randomized frames checked against a bit-list reference model.
module tb_uart_tx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [3:0]  num_data_bits = 4'd8;
    parity_t     parity = PARITY_NONE;
    stop_bits_t  stop_bits = STOP_BITS_1;
    logic [15:0] clks_per_bit = 16'd1;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int checks = 0;
    int fails  = 0;
    bit expQ[$];

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  nb;
        parity_t     par;
        stop_bits_t  stop;
        logic [15:0] cpb;
        logic [11:0] seq;
        int          nBits;
        bit          hold;
        bit          scramble;
    } vec_t;

    vec_t vecs[7];

    uart_tx dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .num_data_bits(num_data_bits),
        .parity       (parity),
        .stop_bits    (stop_bits),
        .clks_per_bit (clks_per_bit),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a list of line levels, one per bit time.
    function automatic void buildFrame(input logic [7:0] d, input logic [3:0] nb,
                                       input parity_t p, input stop_bits_t s);
        int n;
        int ones;
        expQ.delete();
        n = (nb < 5) ? 5 : ((nb > 8) ? 8 : int'(nb));
        ones = 0;
        expQ.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p == PARITY_EVEN) expQ.push_back((ones % 2) == 1);
        if (p == PARITY_ODD)  expQ.push_back((ones % 2) == 0);
        expQ.push_back(1'b1);
        if (s == STOP_BITS_2) expQ.push_back(1'b1);
    endfunction

    function automatic void loadSeq(input logic [11:0] seq, input int n);
        expQ.delete();
        for (int i = 0; i < n; i++) expQ.push_back(seq[11 - i]);
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] nb, input parity_t p,
                                 input stop_bits_t s, input logic [15:0] cpb,
                                 input bit holdValid, input bit scramble, output int waited);
        int eff;
        int len;
        eff = (cpb == 16'd0) ? 1 : int'(cpb);
        len = expQ.size() * eff;
        tx_data       = d;
        num_data_bits = nb;
        parity        = p;
        stop_bits     = s;
        clks_per_bit  = cpb;
        tx_valid      = 1'b1;
        waited        = 0;
        while (!tx_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!tx_ready) begin
            checkOutput("accept_timeout", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!holdValid) tx_valid = 1'b0;
        for (int c = 0; c < len; c++) begin
            checkOutput("tx_bit", 32'(tx), 32'(expQ[c / eff]));
            checkOutput("busy_in_frame", 32'(tx_busy), 32'd1);
            checkOutput("done_early", 32'(tx_done), 32'd0);
            if (scramble && c == 2 * eff) begin
                tx_data       = 8'($urandom);
                num_data_bits = 4'($urandom);
                parity        = parity_t'($urandom_range(0, 2));
                stop_bits     = stop_bits_t'($urandom_range(0, 1));
                clks_per_bit  = 16'($urandom_range(0, 5));
            end
            @(posedge clk); #1;
        end
        checkOutput("done_pulse", 32'(tx_done), 32'd1);
        checkOutput("busy_after", 32'(tx_busy), 32'd0);
        checkOutput("tx_idle", 32'(tx), 32'd1);
        checkOutput("ready_after", 32'(tx_ready), 32'd1);
        if (!holdValid) begin
            @(posedge clk); #1;
            checkOutput("done_once", 32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;

        //            data   nb    parity       stop         cpb    seq (tx order)   n  hold scr
        vecs[0] = '{8'hB1, 4'd8, PARITY_EVEN, STOP_BITS_1, 16'd8, 12'b010001101010, 11, 0, 0};
        vecs[1] = '{8'h15, 4'd5, PARITY_ODD,  STOP_BITS_2, 16'd4, 12'b010101011000,  9, 0, 1};
        vecs[2] = '{8'hA5, 4'd8, PARITY_NONE, STOP_BITS_1, 16'd2, 12'b010100101100, 10, 1, 0};
        vecs[3] = '{8'h3C, 4'd8, PARITY_NONE, STOP_BITS_1, 16'd2, 12'b000111100100, 10, 0, 0};
        vecs[4] = '{8'hE6, 4'd3, PARITY_EVEN, STOP_BITS_1, 16'd3, 12'b001100010000,  8, 0, 0};
        vecs[5] = '{8'h5A, 4'd12, PARITY_ODD, STOP_BITS_1, 16'd2, 12'b001011010110, 11, 0, 0};
        vecs[6] = '{8'h00, 4'd8, PARITY_NONE, STOP_BITS_1, 16'd0, 12'b000000000100, 10, 0, 0};

        // Reset held with a pending byte: nothing may start.
        tx_data       = vecs[0].data;
        num_data_bits = vecs[0].nb;
        parity        = vecs[0].par;
        stop_bits     = vecs[0].stop;
        clks_per_bit  = vecs[0].cpb;
        tx_valid      = 1'b1;
        rst           = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("reset_tx", 32'(tx), 32'd1);
            checkOutput("reset_busy", 32'(tx_busy), 32'd0);
            checkOutput("reset_done", 32'(tx_done), 32'd0);
        end
        checkOutput("reset_ready", 32'(tx_ready), 32'd1);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            loadSeq(vecs[i].seq, vecs[i].nBits);
            applyStimulus(vecs[i].data, vecs[i].nb, vecs[i].par, vecs[i].stop, vecs[i].cpb,
                          vecs[i].hold, vecs[i].scramble, waited);
            if (i == 0) checkOutput("accept_after_reset", 32'(waited), 32'd0);
            if (i > 0 && vecs[i - 1].hold) checkOutput("b2b_gap", 32'(waited), 32'd0);
        end

        // Reset asserted during the parity bit of an 8E1 frame.
        buildFrame(8'h6A, 4'd8, PARITY_EVEN, STOP_BITS_1);
        tx_data       = 8'h6A;
        num_data_bits = 4'd8;
        parity        = PARITY_EVEN;
        stop_bits     = STOP_BITS_1;
        clks_per_bit  = 16'd4;
        tx_valid      = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (9 * 4 + 1) @(posedge clk);
        #1;
        checkOutput("parity_bit_before_reset", 32'(tx), 32'(expQ[9]));
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_tx", 32'(tx), 32'd1);
        checkOutput("midreset_busy", 32'(tx_busy), 32'd0);
        checkOutput("midreset_done", 32'(tx_done), 32'd0);
        checkOutput("midreset_ready", 32'(tx_ready), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("no_done_after_reset", 32'(tx_done), 32'd0);
        end

        // Randomized frames against the reference model.
        for (int i = 0; i < 20; i++) begin
            logic [7:0]  d;
            logic [3:0]  nb;
            parity_t     p;
            stop_bits_t  s;
            logic [15:0] cpb;
            d   = 8'($urandom);
            nb  = 4'($urandom);
            p   = parity_t'($urandom_range(0, 2));
            s   = stop_bits_t'($urandom_range(0, 1));
            cpb = 16'($urandom_range(0, 5));
            buildFrame(d, nb, p, s);
            applyStimulus(d, nb, p, s, cpb, 1'b0, (i % 2) == 1, waited);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts a byte over a valid/ready handshake and serialises it onto `tx` as start bit, 5–8 data bits (LSB first), optional parity and 1 or 2 stop bits. It is the upstream partner of `uart_rx`. Frame format uses the same `uart_pkg` types as the receiver, so a looped-back `tx` line is decoded by `uart_rx` configured identically. Bit timing comes from a runtime clocks-per-bit divisor on the single system clock.

## Interface
- No parameters. Frame types come from `uart_pkg`:
  - `parity_t`: `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`.
  - `stop_bits_t`: `STOP_BITS_1`, `STOP_BITS_2`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset; takes effect at a rising edge of `clk` while 0.
- `tx_data`  in  8  byte to send; only bits [num_data_bits-1:0] are transmitted.
- `tx_valid`  in  1  upstream has a byte.
- `tx_ready`  out  1  block can accept; a transfer occurs on a rising edge with `tx_valid && tx_ready`.
- `num_data_bits`  in  4  data bits per frame; 0–4 treated as 5, 9–15 treated as 8.
- `parity`  in  `parity_t`  parity mode.
- `stop_bits`  in  `stop_bits_t`  stop bit count.
- `clks_per_bit`  in  16  `clk` cycles per bit; 0 treated as 1.
- `tx`  out  1  serial line, idle high; registered output.
- `tx_busy`  out  1  high from the accept edge until the frame completes.
- `tx_done`  out  1  one-cycle pulse when the last stop bit ends.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1, `tx_ready`=1, `tx_busy`=0.
  - On accept, latch `tx_data`, the clamped `num_data_bits`, `parity`, `stop_bits` and the clamped `clks_per_bit`, then go to START.
  - Input changes after the accept edge do not affect the frame in flight.
- START: `tx`=0 for one bit time, then DATA.
- DATA:
  - Sends latched bit 0 up to bit N-1, one bit time each.
  - A 3-bit index counts 0..N-1.
  - After bit N-1, goes to PARITY if parity ≠ NONE, otherwise to STOP.
- PARITY:
  - EVEN: `tx` = XOR of the N sent bits.
  - ODD: `tx` = inverted XOR of the N sent bits.
  - Unsent upper bits are excluded from the calculation.
- STOP: `tx`=1 for 1 or 2 bit times, then IDLE.
- Bit timer: 16-bit counter reloaded at each bit start; the bit ends after exactly `clks_per_bit` cycles.
- Frame length = (1 + N + P + S) × clks_per_bit cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `tx_ready` = (state == IDLE); it is combinational from state.
- Reset mid-frame: at the reset edge, the state goes to IDLE, `tx`=1, counters clear, no `tx_done`, and the latched byte is discarded.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1 (from the first cycle after reset release); state IDLE.
- Accept at edge E: `tx` goes 0 and `tx_busy` goes 1 after edge E.
- The start bit occupies cycles E+1 .. E+clks_per_bit.
- Bit k (start = 0) drives `tx` from edge E+k×clks_per_bit.
- Last stop bit ends at edge F = E + frame length:
  - State returns to IDLE.
  - `tx_done`=1 and `tx_busy`=0 for the cycle after F.
  - `tx_ready`=1 in that cycle.
- Back-to-back: if `tx_valid` is high in the `tx_done` cycle, the next byte is accepted at edge F+1. The minimum inter-frame idle is one cycle of `tx`=1 beyond the stop bits.
- `tx_valid` with `tx_ready`=0 is ignored. No buffering; upstream holds `tx_valid`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `tx_valid`=1 → `tx`=1, `tx_busy`=0, `tx_done`=0, no frame starts. After release, the byte is accepted on the first edge.
- **8E1:** 0xB1, 8 bits, EVEN, STOP_BITS_1, clks_per_bit=8.
  - `tx` sampled mid-bit reads 0, 1,0,0,0,1,1,0,1, parity 0, stop 1.
  - 88 cycles; `tx_done` pulses once at cycle 89; a looped-back `uart_rx` yields `rx_data`=0xB1 with no error.
- **5O2:** 0x15, 5 bits, ODD, STOP_BITS_2, clks_per_bit=4.
  - `tx` reads 0, 1,0,1,0,1, parity 0, stop 1, 1.
  - 36 cycles total.
- **8N1 back-to-back:** 0xA5 then 0x3C with `tx_valid` held, clks_per_bit=2.
  - Frames of 20 cycles each.
  - Second accept occurs exactly one cycle after the first `tx_done`.
  - Data bits read 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- **Mid-frame config change / reset:**
  - Change `parity`, `num_data_bits` and `tx_data` during DATA → the frame is unchanged.
  - Assert `rst` during the parity bit → `tx`=1 the next cycle, no `tx_done`, and a new frame is accepted cleanly afterwards.
- **Clamping:** `num_data_bits`=3 → 5 data bits sent; `num_data_bits`=12 → 8 sent; `clks_per_bit`=0 → 1-cycle bits (8N1 frame = 10 cycles).
